regincr_pipe: RTL
=================

# regincr_pipe

Parametrised, elastic, multi-stage registered incrementer. A message accepted on the input passes through `NSTAGES` pipeline registers. Each stage adds `INCR`, so the output carries `in_msg + NSTAGES*INCR`. Each stage holds its own valid bit and val/rdy handshakes on both sides, so the block drops into latency-insensitive tutorial pipelines and supports back-pressure without losing messages. It generalises the fixed 8-bit, single-register incrementer to arbitrary width, depth and step.

## Interface
- `NBITS`, 8, message width in bits (≥1)
- `NSTAGES`, 2, number of pipeline stages (≥1)
- `INCR`, 1, amount added per stage; must be < 2^NBITS
- `clk` input 1: single clock, posedge
- `reset` input 1: **asynchronous, active-high**; clears all state immediately
- `in_val` input 1: input message valid
- `in_rdy` output 1: block can accept the input message this cycle
- `in_msg` input NBITS: input message
- `out_val` output 1: output message valid
- `out_rdy` input 1: consumer accepts the output message
- `out_msg` output NBITS: incremented message (last-stage register)

## Operation
- Stage k (0..NSTAGES-1) holds `val[k]` and `data[k]`. Stage 0 loads from `in_msg`; stage k loads from `data[k-1]`.
- Load value is `src + INCR`, truncated to NBITS (wrap modulo 2^NBITS). See Configuration for the saturating alternative.
- Stage ready: `rdy[k] = !val[k] || rdy[k+1]`, with `rdy[NSTAGES] = out_rdy`. `in_rdy = rdy[0]`.
- This is a combinational ripple, so a bubble anywhere lets upstream advance.
- Transfers:
  - Input transfer occurs when `in_val && in_rdy`.
  - Output transfer occurs when `out_val && out_rdy`.
  - `out_val = val[NSTAGES-1]` and `out_msg = data[NSTAGES-1]`.
- Stage update on posedge when `rdy[k]`: `val[k] <= val[k-1]` (stage 0 takes `in_val`). `data[k]` loads only when the incoming valid is 1; otherwise it holds.
- When `!rdy[k]`, the stage holds both `val` and `data`.
- Message order is preserved; no message is duplicated or dropped.
- Reset values: all `val[k]=0`, all `data[k]=0`. This gives `out_val=0`, `out_msg=0`, and `in_rdy=1` while reset is asserted.
- Reset mid-operation: in-flight messages are discarded. The first message accepted after reset deassertion behaves as from idle.
- Simultaneous input and output transfer on a full pipeline is legal. `in_rdy` is 1 because `out_rdy=1` ripples back.

## Timing
- Latency: a message accepted at edge t appears on `out_val`/`out_msg` after edge t+NSTAGES-1 and is visible during cycle t+NSTAGES when there is no stall.
- Throughput: 1 message/cycle with `out_rdy` held high.
- Capacity: NSTAGES messages. With `out_rdy=0`, `in_rdy` falls once all stages are valid.
- `in_rdy` depends combinationally on `out_rdy` (no registered skid). Consumers must not make `out_rdy` depend on `in_rdy`.
- Reset is asynchronous on assertion. Deassertion is expected synchronous to `clk` (the system provides the synchroniser).

## Configuration
- Macro: `REGINCR_PIPE_SAT_EN`.
- Defined: each stage computes the sum in NBITS+1 bits and clamps to 2^NBITS-1 on carry-out. The output saturates at all-ones and never wraps.
- Undefined: plain modulo-2^NBITS addition; carry-out is discarded.
- Handshake and timing are identical in both builds.

## Structure
- Shared package `regincr_pkg`:
  - default parameter constants (`REGINCR_DFLT_NBITS`, `REGINCR_DFLT_NSTAGES`, `REGINCR_DFLT_INCR`)
  - the `incr_sat`/`incr_wrap` function used by stages
- Sub-module `regincr_stage`:
  - one val/rdy pipeline stage (valid flop, data flop, adder, rdy logic), parametrised by NBITS/INCR
  - instantiated NSTAGES times in a generate loop
- Top level contains only the generate loop, the ready ripple and the port hookup.

## Test plan
Use defaults (NBITS=8, NSTAGES=2, INCR=1) unless stated.
- Reset: assert `reset` between clock edges with the pipeline full → `out_val=0`, `out_msg=0x00`, `in_rdy=1` before the next edge; the old messages never appear.
- Single message: `in_msg=0x05` accepted at edge 0, `out_rdy=1` → `out_val=1`, `out_msg=0x07` after edge 1, `out_val=0` after edge 2.
- Streaming: 0x10, 0x11, 0x12, 0x13 on consecutive cycles with `out_rdy=1` → outputs 0x12, 0x13, 0x14, 0x15 on consecutive cycles; `in_rdy` stays 1.
- Back-pressure: stream 0x20..0x24 with `out_rdy=0` for cycles 2–5 → `in_rdy` drops after two messages are held. Outputs 0x22..0x26 arrive in order with no loss or duplication.
- Wrap/saturate:
  - Without the macro: input 0xFE → 0x00 and 0xFF → 0x01.
  - With `REGINCR_PIPE_SAT_EN`: both → 0xFF.
- Parameter sweep: NBITS=4, NSTAGES=3, INCR=2, input 0x3 → 0x9 after 3 edges. With the macro, input 0xC → 0xF.

Source files
------------

// File: rtl/regincr_pkg.sv
// Shared constants and per-stage increment functions for the regincr_pipe slice.
// Functions work on a fixed 64-bit container; callers zero-extend their NBITS
// operands in and truncate the result back, so NBITS is limited to 64.
package regincr_pkg;

  localparam int unsigned REGINCR_DFLT_NBITS   = 8;
  localparam int unsigned REGINCR_DFLT_NSTAGES = 2;
  localparam int unsigned REGINCR_DFLT_INCR    = 1;

  localparam int unsigned REGINCR_MAX_NBITS = 64;

  typedef logic [REGINCR_MAX_NBITS-1:0] regincr_word_t;
  typedef logic [REGINCR_MAX_NBITS:0]   regincr_sum_t;

  // All-ones in the low nbits bits; nbits == 64 shifts to zero and wraps to all-ones.
  function automatic regincr_word_t regincr_mask(int unsigned nbits);
    return (regincr_word_t'(1) << nbits) - regincr_word_t'(1);
  endfunction

  // Modulo-2^nbits add; carry-out is discarded.
  function automatic regincr_word_t incr_wrap(regincr_word_t src, regincr_word_t incr,
                                              int unsigned nbits);
    regincr_sum_t sum;
    sum = {1'b0, src} + {1'b0, incr};
    return regincr_word_t'(sum) & regincr_mask(nbits);
  endfunction

  // Add clamped to 2^nbits-1. Operands are below 2^nbits, so any bit at or above
  // position nbits in the sum is the carry-out.
  function automatic regincr_word_t incr_sat(regincr_word_t src, regincr_word_t incr,
                                             int unsigned nbits);
    regincr_sum_t sum;
    logic         carry;
    sum   = {1'b0, src} + {1'b0, incr};
    carry = |(sum >> nbits);
    return carry ? regincr_mask(nbits) : (regincr_word_t'(sum) & regincr_mask(nbits));
  endfunction

endpackage

// File: rtl/regincr_stage.sv
// One val/rdy pipeline stage: valid flop, data flop, incrementer, ready logic.
// Build option: define REGINCR_PIPE_SAT_EN for a saturating add instead of wrapping.
module regincr_stage
  import regincr_pkg::*;
#(
  parameter int unsigned NBITS = REGINCR_DFLT_NBITS,
  parameter int unsigned INCR  = REGINCR_DFLT_INCR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg
);

  logic             val_q;
  logic [NBITS-1:0] data_q;
  logic [NBITS-1:0] data_d;

  // Incremented value of the upstream message.
  always_comb begin
`ifdef REGINCR_PIPE_SAT_EN
    data_d = NBITS'(incr_sat(regincr_word_t'(in_msg), regincr_word_t'(INCR), NBITS));
`else
    data_d = NBITS'(incr_wrap(regincr_word_t'(in_msg), regincr_word_t'(INCR), NBITS));
`endif
  end

  // A stage can take a new message if it is empty or its occupant leaves this cycle.
  assign in_rdy  = !val_q || out_rdy;
  assign out_val = val_q;
  assign out_msg = data_q;

  // Valid follows upstream when ready; data only captures real messages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q  <= 1'b0;
      data_q <= '0;
    end else if (in_rdy) begin
      val_q <= in_val;
      if (in_val) begin
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/regincr_pipe.sv
// Elastic NSTAGES-deep registered incrementer: out_msg = in_msg + NSTAGES*INCR.
// Build option: define REGINCR_PIPE_SAT_EN for saturating stages instead of wrapping.
module regincr_pipe
  import regincr_pkg::*;
#(
  parameter int unsigned NBITS   = REGINCR_DFLT_NBITS,
  parameter int unsigned NSTAGES = REGINCR_DFLT_NSTAGES,
  parameter int unsigned INCR    = REGINCR_DFLT_INCR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_msg
);

  // Index k is the input side of stage k; index NSTAGES is the pipe output.
  logic             chain_val [NSTAGES+1];
  logic [NBITS-1:0] chain_msg [NSTAGES+1];
  logic             rdy       [NSTAGES+1];

  assign chain_val[0] = in_val;
  assign chain_msg[0] = in_msg;
  assign rdy[NSTAGES] = out_rdy;

  assign in_rdy  = rdy[0];
  assign out_val = chain_val[NSTAGES];
  assign out_msg = chain_msg[NSTAGES];

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    regincr_stage #(
      .NBITS(NBITS),
      .INCR (INCR)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .in_val (chain_val[k]),
      .in_rdy (rdy[k]),
      .in_msg (chain_msg[k]),
      .out_val(chain_val[k+1]),
      .out_rdy(rdy[k+1]),
      .out_msg(chain_msg[k+1])
    );
  end

endmodule
